pc_unit: RTL and testbench

Parametrised program-counter unit for the single-cycle and multi-cycle CPU fetch stages. It holds the PC register and selects the next PC from sequential, branch, jump, or register sources. It also supports a synchronous PC load and counts executed fetches. An optional return-address stack (RAS) predicts `jr $ra`-style returns from `jal` pushes.

---
 rtl/pc_unit_if.sv | 29 ++
 rtl/pc_unit.sv | 144 ++++++++++++++
 tb/tb_pc_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-stage bus for pc_unit: next-PC select inputs, PC/link outputs and RAS status.
// The master drives the select/load inputs; the slave (pc_unit) drives the PC outputs.
interface pc_unit_if #(parameter int WIDTH = 32);
  logic             PCWre;
  logic [1:0]       PCSrc;
  logic [WIDTH-1:0] branch_offset;
  logic [25:0]      jump_target;
  logic [WIDTH-1:0] reg_target;
  logic             call;
  logic             ret;
  logic             setPc;
  logic [WIDTH-1:0] initPc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] pc_next;
  logic [31:0]      fetch_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  modport master (
    output PCWre, PCSrc, branch_offset, jump_target, reg_target, call, ret, setPc, initPc,
    input  pc, pc_plus4, pc_next, fetch_count, ras_empty, ras_full, ras_err
  );
  modport slave (
    input  PCWre, PCSrc, branch_offset, jump_target, reg_target, call, ret, setPc, initPc,
    output pc, pc_plus4, pc_next, fetch_count, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with sequential/branch/jump/register next-PC select and fetch counter.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input logic         clk,
  input logic         Reset,
  pc_unit_if.slave    bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      fc_q, fc_d;
  logic [WIDTH-1:0] pc_plus4, br_tgt, jmp_tgt, pc_next;
  logic             ras_hit;
  logic [WIDTH-1:0] ras_top;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign br_tgt   = pc_plus4 + (bus.branch_offset << 2);
  assign jmp_tgt  = {pc_plus4[WIDTH-1:28], bus.jump_target, 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    case (bus.PCSrc)
      2'b00: pc_next = pc_plus4;
      2'b01: pc_next = br_tgt;
      2'b10: pc_next = jmp_tgt;
      2'b11: pc_next = ras_hit ? ras_top : bus.reg_target;
      default: pc_next = pc_plus4;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    fc_d = fc_q;
    if (bus.setPc) begin
      pc_d = bus.initPc;
    end else if (bus.PCWre) begin
      pc_d = pc_next;
      fc_d = fc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      pc_q <= RESET_PC;
      fc_q <= '0;
    end else begin
      pc_q <= pc_d;
      fc_q <= fc_d;
    end
  end

`ifdef PC_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);

  // Circular buffer: ptr_q is the next write slot, so a push when full lands on the oldest entry.
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d, top_idx;
  logic [AW:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             empty, full, upd;

  assign top_idx = ptr_q - AW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(RAS_DEPTH));
  assign ras_top = ras_q[top_idx];
  assign ras_hit = bus.ret && !empty;
  assign upd     = bus.PCWre && !bus.setPc;

  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (upd) begin
      case ({bus.call, bus.ret})
        2'b10: begin
          ras_d[ptr_q] = pc_plus4;
          ptr_d        = ptr_q + AW'(1);
          if (full) err_d = 1'b1;
          else      cnt_d = cnt_q + 1'b1;
        end
        2'b01: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
          end
        end
        2'b11: begin
          if (empty) begin
            ras_d[ptr_q] = pc_plus4;
            ptr_d        = ptr_q + AW'(1);
            cnt_d        = cnt_q + 1'b1;
            err_d        = 1'b1;
          end else begin
            ras_d[top_idx] = pc_plus4;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entries need no reset: they are only read while cnt_q says they are valid.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_err   = err_q;
`else
  logic unused_ras;
  assign unused_ras    = ^{bus.call, bus.ret};
  assign ras_hit       = 1'b0;
  assign ras_top       = '0;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_err   = 1'b0;
`endif

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.pc_next     = pc_next;
  assign bus.fetch_count = fc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, RAS sequences, and
// randomized traffic against a queue-based reference model.
module tb_pc_unit;
  localparam int W = 32;
  localparam int D = 4;

  logic clk = 1'b0;
  logic Reset;
  pc_unit_if #(.WIDTH(W)) bus ();

  pc_unit #(.WIDTH(W), .RESET_PC('0), .RAS_DEPTH(D)) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, set, we;
    logic [1:0]  src;
    logic [31:0] boff;
    logic [25:0] jt;
    logic [31:0] rt;
    logic        cl, rtn;
    logic [31:0] init;
    logic [31:0] epc, efc;
  } vec_t;

  function automatic vec_t mk(logic rst, logic set, logic we, logic [1:0] src, logic [31:0] boff,
                              logic [25:0] jt, logic [31:0] rt, logic cl, logic rtn,
                              logic [31:0] init, logic [31:0] epc, logic [31:0] efc);
    vec_t v;
    v.rst = rst; v.set = set; v.we = we; v.src = src; v.boff = boff; v.jt = jt; v.rt = rt;
    v.cl = cl; v.rtn = rtn; v.init = init; v.epc = epc; v.efc = efc;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic set, input logic we, input logic [1:0] src,
                       input logic [31:0] boff, input logic [25:0] jt, input logic [31:0] rt,
                       input logic cl, input logic rtn, input logic [31:0] init);
    Reset = rst; bus.setPc = set; bus.PCWre = we; bus.PCSrc = src;
    bus.branch_offset = boff; bus.jump_target = jt; bus.reg_target = rt;
    bus.call = cl; bus.ret = rtn; bus.initPc = init;
  endtask

  // One clocked RAS-test cycle followed by a pc check.
  task automatic ras_cyc(input string name, input logic [1:0] src, input logic [25:0] jt,
                         input logic cl, input logic rtn, input logic [31:0] epc);
    @(negedge clk);
    drive(0, 0, 1, src, 32'h0, jt, 32'h0000DEAD, cl, rtn, 32'h0);
    @(posedge clk); #1;
    chk(name, bus.pc, epc);
  endtask

  // Reference model state
  logic [31:0] m_pc, m_fc;
  logic [31:0] m_q[$];
  logic        m_err;

  function automatic logic [31:0] model_next(logic [31:0] pc, logic [1:0] src, logic [31:0] boff,
                                              logic [25:0] jt, logic [31:0] rt, logic rtn);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    case (src)
      2'd0: return p4;
      2'd1: return p4 + boff * 4;
      2'd2: return {p4[31:28], jt, 2'b00};
      default: begin
`ifdef PC_RAS_EN
        if (rtn && m_q.size() > 0) return m_q[m_q.size()-1];
`endif
        return rt;
      end
    endcase
  endfunction

  vec_t tbl[16];

  initial begin
    drive(1, 0, 0, 2'd0, 32'h0, 26'h0, 32'h0, 0, 0, 32'h0);

    tbl[0]  = mk(1,0,0,2'd0,32'h0,       26'h0,      32'h0,     0,0,32'h0,       32'h0,       0);
    tbl[1]  = mk(0,0,1,2'd0,32'h0,       26'h0,      32'h0,     0,0,32'h0,       32'h4,       1);
    tbl[2]  = mk(0,0,1,2'd0,32'h0,       26'h0,      32'h0,     0,0,32'h0,       32'h8,       2);
    tbl[3]  = mk(0,0,1,2'd0,32'h0,       26'h0,      32'h0,     0,0,32'h0,       32'hC,       3);
    tbl[4]  = mk(0,0,1,2'd0,32'h0,       26'h0,      32'h0,     0,0,32'h0,       32'h10,      4);
    tbl[5]  = mk(0,0,1,2'd1,32'hFFFFFFFE,26'h0,      32'h0,     0,0,32'h0,       32'h0C,      5);
    tbl[6]  = mk(0,0,1,2'd2,32'h0,       26'h40,     32'h0,     0,0,32'h0,       32'h100,     6);
    tbl[7]  = mk(0,0,0,2'd1,32'h5,       26'h0,      32'h0,     0,0,32'h0,       32'h100,     6);
    tbl[8]  = mk(0,1,1,2'd1,32'h10,      26'h0,      32'h0,     0,0,32'h00400000,32'h00400000,6);
    tbl[9]  = mk(1,1,1,2'd0,32'h0,       26'h0,      32'h0,     0,0,32'h00400000,32'h0,       0);
    tbl[10] = mk(0,0,1,2'd3,32'h0,       26'h0,      32'hDEAD,  1,1,32'h0,       32'hDEAD,    1);
    tbl[11] = mk(0,1,0,2'd0,32'h0,       26'h0,      32'h0,     0,0,32'hFFFFFFFC,32'hFFFFFFFC,1);
    tbl[12] = mk(0,0,1,2'd0,32'h0,       26'h0,      32'h0,     0,0,32'h0,       32'h0,       2);
    tbl[13] = mk(0,0,1,2'd1,32'h3FFFFFFF,26'h0,      32'h0,     0,0,32'h0,       32'h0,       3);
    tbl[14] = mk(0,0,1,2'd2,32'h0,       26'h3FFFFFF,32'h0,     0,0,32'h0,       32'h0FFFFFFC,4);
    tbl[15] = mk(0,0,1,2'd2,32'h0,       26'h1,      32'h0,     0,0,32'h0,       32'h10000004,5);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].set, tbl[i].we, tbl[i].src, tbl[i].boff, tbl[i].jt, tbl[i].rt,
            tbl[i].cl, tbl[i].rtn, tbl[i].init);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.pc", i), bus.pc, tbl[i].epc);
      chk($sformatf("tbl%0d.fc", i), bus.fetch_count, tbl[i].efc);
`ifndef PC_RAS_EN
      chk($sformatf("tbl%0d.flags", i), {29'h0, bus.ras_empty, bus.ras_full, bus.ras_err}, 32'h4);
`endif
    end

`ifdef PC_RAS_EN
    // Two calls, two predicted returns, then an underflowing return.
    @(negedge clk); drive(1, 0, 0, 2'd0, 32'h0, 26'h0, 32'h0, 0, 0, 32'h0);
    @(negedge clk); drive(0, 1, 0, 2'd0, 32'h0, 26'h0, 32'h0, 0, 0, 32'h100);
    @(posedge clk); #1; chk("ras.set", bus.pc, 32'h100);
    ras_cyc("ras.call1", 2'd2, 26'h80,  1, 0, 32'h200);
    ras_cyc("ras.call2", 2'd2, 26'h100, 1, 0, 32'h400);
    ras_cyc("ras.ret1",  2'd3, 26'h0,   0, 1, 32'h204);
    ras_cyc("ras.ret2",  2'd3, 26'h0,   0, 1, 32'h104);
    chk("ras.empty", {31'h0, bus.ras_empty}, 32'h1);
    chk("ras.err0",  {31'h0, bus.ras_err},   32'h0);
    ras_cyc("ras.ret3",  2'd3, 26'h0,   0, 1, 32'hDEAD);
    chk("ras.err1",  {31'h0, bus.ras_err},   32'h1);

    // Overflow: five calls keep only the four newest links.
    @(negedge clk); drive(1, 0, 0, 2'd0, 32'h0, 26'h0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++)
      ras_cyc($sformatf("ovf.call%0d", i), 2'd0, 26'h0, 1, 0, 32'(4 * (i + 1)));
    chk("ovf.full", {30'h0, bus.ras_full, bus.ras_err}, 32'h3);
    for (int i = 0; i < 4; i++)
      ras_cyc($sformatf("ovf.pop%0d", i), 2'd3, 26'h0, 0, 1, 32'(4 * (5 - i)));
    chk("ovf.empty", {30'h0, bus.ras_empty, bus.ras_full}, 32'h2);
`endif

    // Randomized traffic vs. reference model
    @(negedge clk); drive(1, 0, 0, 2'd0, 32'h0, 26'h0, 32'h0, 0, 0, 32'h0);
    @(posedge clk); #1;
    m_pc = 32'h0; m_fc = 32'h0; m_q.delete(); m_err = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_set, r_we, r_cl, r_rt;
      logic [1:0]  r_src;
      logic [31:0] r_boff, r_rtg, r_init, exp_next, p4;
      logic [25:0] r_jt;
      r_rst  = ($urandom_range(0, 31) == 0);
      r_set  = ($urandom_range(0, 15) == 0);
      r_we   = ($urandom_range(0, 3) != 0);
      r_src  = 2'($urandom_range(0, 3));
      r_boff = $urandom;
      r_jt   = 26'($urandom);
      r_rtg  = $urandom;
      r_init = $urandom;
      r_cl   = ($urandom_range(0, 2) == 0);
      r_rt   = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      drive(r_rst, r_set, r_we, r_src, r_boff, r_jt, r_rtg, r_cl, r_rt, r_init);
      #1;
      p4 = m_pc + 32'd4;
      exp_next = model_next(m_pc, r_src, r_boff, r_jt, r_rtg, r_rt);
      chk("rnd.pc_plus4", bus.pc_plus4, p4);
      chk("rnd.pc_next",  bus.pc_next,  exp_next);
      if (r_rst) begin
        m_pc = 32'h0; m_fc = 32'h0; m_q.delete(); m_err = 1'b0;
      end else if (r_set) begin
        m_pc = r_init;
      end else if (r_we) begin
        m_pc = exp_next;
        m_fc = m_fc + 32'd1;
`ifdef PC_RAS_EN
        if (r_cl && !r_rt) begin
          m_q.push_back(p4);
          if (m_q.size() > D) begin
            void'(m_q.pop_front());
            m_err = 1'b1;
          end
        end else if (r_rt && !r_cl) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
          else m_err = 1'b1;
        end else if (r_rt && r_cl) begin
          if (m_q.size() == 0) begin
            m_q.push_back(p4);
            m_err = 1'b1;
          end else begin
            m_q[m_q.size()-1] = p4;
          end
        end
`endif
      end
      @(posedge clk); #1;
      chk("rnd.pc", bus.pc, m_pc);
      chk("rnd.fc", bus.fetch_count, m_fc);
      chk("rnd.flags", {29'h0, bus.ras_empty, bus.ras_full, bus.ras_err},
          {29'h0, m_q.size() == 0, m_q.size() == D, m_err});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
